// File: rtl/note_player_if.sv
// Note handshake bundle between the melody ROM sequencer and the tone player.
//   note_valid : sequencer presents a note on note_div/note_dur
//   note_ready : player can accept a note (it is idle)
//   note_div   : half-period of the tone in clocks, 0 = rest
//   note_dur   : note length in ticks, 0 = discard
// Modports: master = sequencer side, slave = player side.
interface note_if #(
  parameter int DW = 16
);
  logic          note_valid;
  logic          note_ready;
  logic [DW-1:0] note_div;
  logic [7:0]    note_dur;

  modport master (
    output note_valid,
    output note_div,
    output note_dur,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_div,
    input  note_dur,
    output note_ready
  );
endinterface

// File: rtl/note_player.sv
// Single-channel square-wave tone player.
// Accepts one note (half-period divisor + duration in ticks) over the note_if
// handshake, plays it on ch_out, appends GAP silent ticks, then pulses done.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : note_if slave (note_valid/note_ready/note_div/note_dur)
//   ch_out : registered square-wave output
//   busy   : high while a note or its gap is in progress
//   done   : one-clock pulse in the first idle cycle after a note completes
//            or is discarded
//
// state  | meaning
// S_IDLE | waiting for a note, note_ready high
// S_PLAY | tone (or rest) for dur*TICK cycles
// S_GAP  | silent articulation gap for GAP*TICK cycles
module note_player #(
  parameter int TICK = 12000,
  parameter int GAP  = 10,
  parameter int DW   = 16
) (
  input  logic   clk,
  input  logic   rst,
  note_if.slave  bus,
  output logic   ch_out,
  output logic   busy,
  output logic   done
);

  localparam int             PW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK - 1);
  localparam logic [7:0]     GAP_TICKS = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t        state;
  logic [DW-1:0] div_q;
  logic [7:0]    dur_q;
  logic [DW-1:0] tone_cnt;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    tick_cnt;

  logic          tick_wrap;
  logic          tone_last;
  logic [7:0]    tick_next;

  assign tick_wrap = (pre_cnt == PRE_LAST);
  assign tone_last = (tone_cnt == (div_q - DW'(1)));
  assign tick_next = tick_cnt + 8'd1;

  assign bus.note_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      div_q    <= '0;
      dur_q    <= '0;
      tone_cnt <= '0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
      ch_out   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.note_valid) begin
            div_q    <= bus.note_div;
            dur_q    <= bus.note_dur;
            tone_cnt <= '0;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            ch_out   <= 1'b0;
            // A zero-length note is consumed without ever leaving idle.
            if (bus.note_dur != 8'd0) begin
              state <= S_PLAY;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_PLAY: begin
          // div_q == 0 is a rest: counter frozen, ch_out stays low.
          if (div_q != '0) begin
            if (tone_last) begin
              tone_cnt <= '0;
              ch_out   <= ~ch_out;
            end else begin
              tone_cnt <= tone_cnt + DW'(1);
            end
          end
          if (tick_wrap) begin
            pre_cnt <= '0;
            if (tick_next == dur_q) begin
              // Silence on the same edge PLAY ends; overrides any toggle above.
              tick_cnt <= '0;
              tone_cnt <= '0;
              ch_out   <= 1'b0;
              if (GAP == 0) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state <= S_GAP;
              end
            end else begin
              tick_cnt <= tick_next;
            end
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end

        S_GAP: begin
          if (tick_wrap) begin
            pre_cnt <= '0;
            if (tick_next == GAP_TICKS) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
              done     <= 1'b1;
            end else begin
              tick_cnt <= tick_next;
            end
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          ch_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
